alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
// - Command-side initiator for the combinational ALU: accepts {op, A, B} on a valid/ready input, drives the ALU OP/A/B bus, registers R, returns the result on a valid/ready output.
// - Extends the ALU's single-step ops: RSH/LSH repeat by B[CW-1:0]; optional shift-add MUL.
// - Sits between the instruction/UART command decode and an external ALU instance (not instantiated here).
// PARAMETERS
// - BIT_WIDTH  32  datapath width; must match the attached ALU's bit_width
// - CW  $clog2(BIT_WIDTH)  shift-count width (localparam)
// PORTS
// - clk  in  1  single clock, rising edge
// - rst_n  in  1  asynchronous, active-low reset
// - in_valid  in  1  command valid
// - in_ready  out  1  sequencer can accept (high only in IDLE)
// - in_op  in  4  opcode (alu_pkg::alu_op_e)
// - in_a / in_b  in  BIT_WIDTH  operands
// - out_valid  out  1  result valid, held until out_ready
// - out_ready  in  1  result consumer ready
// - out_r  out  BIT_WIDTH  result
// - out_err  out  1  illegal opcode flag, qualified by out_valid
// - alu_op  out  4  to ALU OP
// - alu_a / alu_b  out  BIT_WIDTH  to ALU A/B
// - alu_r  in  BIT_WIDTH  from ALU R
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_r=0, out_err=0, alu_op=OP_ADD, alu_a=alu_b=0; in-flight command dropped.
// - Opcodes: 0 ADD,1 SUB,2 NOT,3 AND,4 OR,5 XOR,6 RSH,7 LSH,8 GT,9 EQ,10 LT,11 MUL (macro only); 12-15 (and 11 without macro) illegal.
// - Accept = in_valid & in_ready at a rising edge; operands captured into op_q/a_q/b_q.
// - FSM: IDLE -> EXEC (ops 0-5,8-10, illegal) | SHIFT (6,7) | MUL (11); EXEC/SHIFT/MUL -> DONE; DONE -> IDLE on out_ready.
// - EXEC: alu_op=op_q, alu_a=a_q, alu_b=b_q; next edge out_r<=alu_r, DONE. Latency: out_valid high 1 edge after accept.
// - Illegal op: EXEC drives OP_ADD, out_r<=0, out_err<=1; same latency.
// - SHIFT: acc<=a_q, cnt<=b_q[CW-1:0] at accept; alu_op=op_q, alu_a=acc; each edge with cnt!=0: acc<=alu_r, cnt--; edge with cnt==0: out_r<=acc, DONE. Shift by n: out_valid n+1 edges after accept; n=0 returns A in 1.
// - Upper bits of B beyond CW ignored; shifts are logical (zero fill).
// - DONE: out_valid=1, out_r/out_err stable until out_ready; in_ready=0; no new accept same edge as out handshake (IDLE next cycle).
// - Outside EXEC/SHIFT/MUL: alu_op=OP_ADD, alu_a=alu_b=0 (quiet bus).
// - SUB/compare semantics are the ALU's (A-B mod 2^W; unsigned compares, all-ones/all-zeros result).
// CONFIGURATION
// - ALU_SEQ_MUL_EN defined: op 11 = unsigned multiply, low BIT_WIDTH bits of A*B.
//   acc<=0, mc<=a_q, mp<=b_q; alu_op=OP_ADD, alu_a=acc, alu_b=mc; each edge mp!=0: if mp[0] acc<=alu_r; mc<<=1; mp>>=1; mp==0: out_r<=acc, DONE.
//   Latency = k+1 edges, k = index of highest set bit of B plus 1 (k=0 for B=0).
// - Not defined: MUL state/registers absent; op 11 treated as illegal (out_err=1, out_r=0).
// STRUCTURE
// - alu_pkg: alu_op_e enum (codes 0-11 above, OP_MUL=11), seq_state_e {IDLE,EXEC,SHIFT,MUL,DONE}; shared with ALU and decode.
// - Single module, no sub-module; ALU connected externally at the top level.
// TESTING (bench instantiates ALU with BIT_WIDTH=32 behind the sequencer)
// - SUB A=5,B=7 -> out_r=32'hFFFF_FFFE, out_err=0, out_valid 1 edge after accept.
// - LSH A=1,B=31 -> out_r=32'h8000_0000 after 32 edges; RSH A=32'h8000_0000,B=32'h21 (count 1) -> 32'h4000_0000 after 2 edges.
// - Backpressure: out_ready=0 for 5 cycles in DONE -> out_r stable, in_ready=0, second in_valid not accepted until handshake.
// - in_op=4'hF -> out_err=1, out_r=0, latency 1; next legal command completes normally.
// - rst_n pulsed low mid-SHIFT (LSH B=20) -> immediately out_valid=0, in_ready=1, alu bus quiet; next ADD 2+3 -> 5.
// - ALU_SEQ_MUL_EN: MUL 12*10 -> 120 after 5 edges; MUL B=0 -> 0 after 1; without macro op 11 -> out_err=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, sequencer state encoding and an
// opcode legality helper. Used by the ALU, the command decode and the
// sequencer.
// Optional feature macro: ALU_SEQ_MUL_EN (makes OP_MUL a legal opcode).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_NOT = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_RSH = 4'd6,
    OP_LSH = 4'd7,
    OP_GT  = 4'd8,
    OP_EQ  = 4'd9,
    OP_LT  = 4'd10,
    OP_MUL = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SHIFT,
    MUL,
    DONE
  } seq_state_e;

  // Opcodes 0-10 always legal; 11 only when the multiplier is built in.
  function automatic logic op_legal(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
    return (op <= 4'd11);
`else
    return (op <= 4'd10);
`endif
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side initiator for an external combinational ALU.
// Accepts {op, A, B} on a valid/ready input, drives the ALU OP/A/B bus,
// registers the result and returns it on a valid/ready output. RSH/LSH are
// repeated B[CW-1:0] times; an optional shift-add multiply is available.
// Optional feature macro: ALU_SEQ_MUL_EN (op 11 = unsigned multiply).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     command handshake; in_ready high only in IDLE
//   in_op, in_a, in_b     opcode and operands
//   out_valid/out_ready   result handshake; result held until out_ready
//   out_r, out_err        result and illegal-opcode flag
//   alu_op, alu_a, alu_b  to the external ALU
//   alu_r                 from the external ALU
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_r,
  output logic                 out_err,
  output logic [3:0]           alu_op,
  output logic [BIT_WIDTH-1:0] alu_a,
  output logic [BIT_WIDTH-1:0] alu_b,
  input  logic [BIT_WIDTH-1:0] alu_r
);

  localparam int CW = $clog2(BIT_WIDTH);

  seq_state_e state, state_n;

  logic [3:0]           op_q;
  logic [BIT_WIDTH-1:0] a_q, b_q;
  logic [BIT_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
`ifdef ALU_SEQ_MUL_EN
  logic [BIT_WIDTH-1:0] mc, mp;
`endif

  logic accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    alu_op  = OP_ADD;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_op == OP_RSH || in_op == OP_LSH) state_n = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          else if (in_op == OP_MUL)               state_n = MUL;
`endif
          else                                    state_n = EXEC;
        end
      end
      EXEC: begin
        alu_op  = op_legal(op_q) ? op_q : OP_ADD;
        alu_a   = a_q;
        alu_b   = b_q;
        state_n = DONE;
      end
      SHIFT: begin
        alu_op = op_q;
        alu_a  = acc;
        if (cnt == '0) state_n = DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        alu_op = OP_ADD;
        alu_a  = acc;
        alu_b  = mc;
        if (mp == '0) state_n = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_r   <= '0;
      out_err <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mc      <= '0;
      mp      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= in_op;
            a_q  <= in_a;
            b_q  <= in_b;
            // acc doubles as shift accumulator and multiply partial sum.
            acc  <= in_a;
            cnt  <= in_b[CW-1:0];
`ifdef ALU_SEQ_MUL_EN
            if (in_op == OP_MUL) acc <= '0;
            mc   <= in_a;
            mp   <= in_b;
`endif
          end
        end
        EXEC: begin
          out_r   <= op_legal(op_q) ? alu_r : '0;
          out_err <= ~op_legal(op_q);
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= alu_r;
            cnt <= cnt - CW'(1);
          end else begin
            out_r   <= acc;
            out_err <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          if (mp != '0) begin
            if (mp[0]) acc <= alu_r;
            mc <= mc << 1;
            mp <= mp >> 1;
          end else begin
            out_r   <= acc;
            out_err <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a behavioural 32-bit ALU model behind it.
// Optional feature macro: ALU_SEQ_MUL_EN (selects the multiply tests).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_r;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.BIT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_err   (out_err),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_r     (alu_r)
  );

  // Single-step external ALU: shifts move one bit, compares are unsigned.
  always_comb begin
    alu_r = '0;
    case (alu_op)
      4'd0:  alu_r = alu_a + alu_b;
      4'd1:  alu_r = alu_a - alu_b;
      4'd2:  alu_r = ~alu_a;
      4'd3:  alu_r = alu_a & alu_b;
      4'd4:  alu_r = alu_a | alu_b;
      4'd5:  alu_r = alu_a ^ alu_b;
      4'd6:  alu_r = alu_a >> 1;
      4'd7:  alu_r = alu_a << 1;
      4'd8:  alu_r = (alu_a > alu_b)  ? '1 : '0;
      4'd9:  alu_r = (alu_a == alu_b) ? '1 : '0;
      4'd10: alu_r = (alu_a < alu_b)  ? '1 : '0;
      default: alu_r = '0;
    endcase
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic handshake;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_r !== 32'h0) $display("FAIL reset_out_r got %h want 0", out_r); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL reset_out_err got %b want 0", out_err); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_a, alu_b} !== 68'h0) $display("FAIL reset_alu_bus got %h/%h/%h want 0/0/0", alu_op, alu_a, alu_b); else pass_cnt++;
  endtask

  task automatic test_sub;
    int lat;
    send(4'd1, 32'd5, 32'd7);
    wait_valid(lat);
    total_cnt++; if (lat !== 1) $display("FAIL sub_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (out_r !== 32'hFFFF_FFFE) $display("FAIL sub_r got %h want fffffffe", out_r); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL sub_err got %b want 0", out_err); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_a, alu_b} !== 68'h0) $display("FAIL done_bus_quiet got %h/%h/%h want 0/0/0", alu_op, alu_a, alu_b); else pass_cnt++;
    handshake();
  endtask

  task automatic test_ops;
    logic [3:0]  ops  [8] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd2, 4'd8, 4'd9, 4'd10};
    logic [31:0] as   [8] = '{32'hFFFF_FFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h0, 32'h8000_0000, 32'd5, 32'd3};
    logic [31:0] bs   [8] = '{32'd2, 32'hFF00, 32'hFF00, 32'hFF00, 32'h0, 32'd1, 32'd6, 32'd7};
    logic [31:0] exps [8] = '{32'd1, 32'hF000, 32'hFFF0, 32'h0FF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_valid(lat);
      total_cnt++;
      if (lat !== 1 || out_r !== exps[i] || out_err !== 1'b0)
        $display("FAIL op%0d got r=%h err=%b lat=%0d want r=%h err=0 lat=1", ops[i], out_r, out_err, lat, exps[i]);
      else pass_cnt++;
      handshake();
    end
  endtask

  task automatic test_shift;
    int lat;
    send(4'd7, 32'd1, 32'd31);
    wait_valid(lat);
    total_cnt++; if (lat !== 32 || out_r !== 32'h8000_0000) $display("FAIL lsh31 got r=%h lat=%0d want r=80000000 lat=32", out_r, lat); else pass_cnt++;
    handshake();
    send(4'd6, 32'h8000_0000, 32'h21);
    wait_valid(lat);
    total_cnt++; if (lat !== 2 || out_r !== 32'h4000_0000) $display("FAIL rsh_b21 got r=%h lat=%0d want r=40000000 lat=2", out_r, lat); else pass_cnt++;
    handshake();
    send(4'd7, 32'h1234_5678, 32'd0);
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'h1234_5678) $display("FAIL lsh0 got r=%h lat=%0d want r=12345678 lat=1", out_r, lat); else pass_cnt++;
    handshake();
  endtask

  task automatic test_back_to_back;
    int lat;
    send(4'd0, 32'd2, 32'd3);
    wait_valid(lat);
    @(negedge clk);
    in_op = 4'd0; in_a = 32'd4; in_b = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_r !== 32'd5)
        $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h want v=1 rdy=0 r=5", i, out_valid, in_ready, out_r);
      else pass_cnt++;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_no_same_edge_accept got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    else pass_cnt++;
    @(posedge clk); #1; in_valid = 1'b0;
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'd9) $display("FAIL bp_second got r=%h lat=%0d want r=9 lat=1", out_r, lat); else pass_cnt++;
    handshake();
  endtask

  task automatic test_illegal;
    int lat;
    send(4'hF, 32'd9, 32'd9);
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'h0 || out_err !== 1'b1) $display("FAIL illegal got r=%h err=%b lat=%0d want r=0 err=1 lat=1", out_r, out_err, lat); else pass_cnt++;
    handshake();
    send(4'd0, 32'd10, 32'd20);
    wait_valid(lat);
    total_cnt++; if (out_r !== 32'd30 || out_err !== 1'b0) $display("FAIL after_illegal got r=%h err=%b want r=1e err=0", out_r, out_err); else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_mid;
    int lat;
    send(4'd7, 32'd1, 32'd20);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {alu_op, alu_a, alu_b} !== 68'h0)
      $display("FAIL mid_reset got v=%b rdy=%b bus=%h/%h/%h want v=1'b0 rdy=1 bus=0", out_valid, in_ready, alu_op, alu_a, alu_b);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    send(4'd0, 32'd2, 32'd3);
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'd5) $display("FAIL post_reset_add got r=%h lat=%0d want r=5 lat=1", out_r, lat); else pass_cnt++;
    handshake();
  endtask

  task automatic test_mul;
    int lat;
`ifdef ALU_SEQ_MUL_EN
    send(4'd11, 32'd12, 32'd10);
    wait_valid(lat);
    total_cnt++; if (lat !== 5 || out_r !== 32'd120 || out_err !== 1'b0) $display("FAIL mul12x10 got r=%h lat=%0d err=%b want r=78 lat=5 err=0", out_r, lat, out_err); else pass_cnt++;
    handshake();
    send(4'd11, 32'd77, 32'd0);
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'd0) $display("FAIL mul_b0 got r=%h lat=%0d want r=0 lat=1", out_r, lat); else pass_cnt++;
    handshake();
`else
    send(4'd11, 32'd12, 32'd10);
    wait_valid(lat);
    total_cnt++; if (lat !== 1 || out_r !== 32'h0 || out_err !== 1'b1) $display("FAIL op11_illegal got r=%h err=%b lat=%0d want r=0 err=1 lat=1", out_r, out_err, lat); else pass_cnt++;
    handshake();
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_sub();
    test_ops();
    test_shift();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
